// File: rtl/mem_agen_buffer_pkg.sv
// Shared memory-pipe types and configuration constants.
//   memPkt                 : AGEN result packet (valid flag + payload)
//   MEM_AGEN_BUF_DEPTH     : entries in the AGEN->LSU elastic buffer
//   MEM_AGEN_STALL_MARGIN  : packets still in flight after memStall_o rises
package mem_agen_buffer_pkg;

  localparam int unsigned MEM_AGEN_BUF_DEPTH    = 4;
  localparam int unsigned MEM_AGEN_STALL_MARGIN = 2;

  localparam int unsigned SEQ_W  = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned ADDR_W = 32;

  typedef struct packed {
    logic              valid;
    logic [SEQ_W-1:0]  seq_no;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
  } memPkt;

endpackage

// File: rtl/mem_agen_buffer.sv
// Elastic buffer between the AGEN stage and the LSU execute port.
// Holds up to DEPTH packets in order, raises a registered stall towards the
// memory issue queue before it can overflow, and flushes on recovery.
//
// Optional feature (macro MEM_AGEN_BYPASS_EN): when the buffer is empty and the
// LSU is ready, the incoming packet is handed straight through with zero
// latency instead of being enqueued.
//
// Ports:
//   clk            core clock, rising edge
//   reset_n        asynchronous active-low reset
//   memPacket_i    packet from AGEN (.valid requests a push)
//   recoverFlag_i  pipeline recovery, flushes everything
//   lsuReady_i     LSU accepts memPacket_o this cycle
//   memPacket_o    head packet (combinational), .valid when presented
//   memStall_o     registered stall to the memory issue queue
//   count_o        registered occupancy
//   overflow_o     sticky: a push was dropped because the buffer was full
module mem_agen_buffer
  import mem_agen_buffer_pkg::*;
#(
  parameter int unsigned DEPTH        = MEM_AGEN_BUF_DEPTH,
  parameter int unsigned STALL_MARGIN = MEM_AGEN_STALL_MARGIN
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  memPkt                  memPacket_i,
  input  logic                   recoverFlag_i,
  input  logic                   lsuReady_i,
  output memPkt                  memPacket_o,
  output logic                   memStall_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] STALL_TH = PTR_W'(DEPTH - STALL_MARGIN);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             stall_q, stall_d;
  logic             ovf_q, ovf_d;

  memPkt mem_q [DEPTH];

  logic empty_c;
  logic full_c;
  logic bypass_c;
  logic pop_c;
  logic deq_c;
  logic push_c;

  // Pointer-derived status: wrap bit distinguishes full from empty.
  always_comb begin
    empty_c = (head_q == tail_q);
    full_c  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
              (head_q[IDX_W] != tail_q[IDX_W]);
  end

  // Output selection; empty storage presents an all-zero packet.
  always_comb begin
    memPacket_o = '0;
    bypass_c    = 1'b0;
    if (!empty_c) begin
      memPacket_o = mem_q[head_q[IDX_W-1:0]];
    end
`ifdef MEM_AGEN_BYPASS_EN
    else if (reset_n && memPacket_i.valid && !recoverFlag_i) begin
      memPacket_o = memPacket_i;
      bypass_c    = 1'b1;
    end
`endif
  end

  // Handshake: a bypassed packet that the LSU takes is never enqueued.
  always_comb begin
    pop_c  = memPacket_o.valid && lsuReady_i;
    deq_c  = pop_c && !empty_c;
    push_c = memPacket_i.valid && !recoverFlag_i && (!full_c || pop_c) &&
             !(bypass_c && pop_c);
  end

  // Next-state for pointers, occupancy, stall and sticky overflow.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    stall_d = 1'b0;
    if (recoverFlag_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_c) tail_d = tail_q + PTR_W'(1);
      if (deq_c)  head_d = head_q + PTR_W'(1);
      count_d = count_q + PTR_W'(push_c) - PTR_W'(deq_c);
      if (memPacket_i.valid && full_c && !pop_c) ovf_d = 1'b1;
      stall_d = (count_d >= STALL_TH);
    end
  end

  // Control state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      stall_q <= stall_d;
      ovf_q   <= ovf_d;
    end
  end

  // Payload storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[tail_q[IDX_W-1:0]] <= memPacket_i;
  end

  assign memStall_o = stall_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_mem_agen_buffer.sv
// Self-checking bench for mem_agen_buffer (default build, DEPTH=4, STALL_MARGIN=2).
module tb_mem_agen_buffer;
  import mem_agen_buffer_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned MARGIN = 2;
  localparam int unsigned CW     = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  memPkt         pkt_i;
  logic          rec;
  logic          rdy;
  memPkt         pkt_o;
  logic          stall;
  logic [CW-1:0] cnt;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  memPkt mq[$];
  logic  m_stall;
  logic  m_ovf;

  always #5 clk = ~clk;

  mem_agen_buffer #(.DEPTH(DEPTH), .STALL_MARGIN(MARGIN)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .memPacket_i   (pkt_i),
    .recoverFlag_i (rec),
    .lsuReady_i    (rdy),
    .memPacket_o   (pkt_o),
    .memStall_o    (stall),
    .count_o       (cnt),
    .overflow_o    (ovf)
  );

  typedef struct {
    logic       v;
    logic [7:0] s;
    logic       rc;
    logic       rd;
    logic       e_valid;
    logic [7:0] e_seq;
    logic [2:0] e_cnt;
    logic       e_stall;
    logic       e_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic memPkt mk(input logic v, input logic [7:0] s);
    memPkt p;
    p.valid  = v;
    p.seq_no = s;
    p.op     = 4'(s);
    p.addr   = 32'h1000_0000 + 32'(s);
    return p;
  endfunction

  function automatic vec_t V(input int v, input int s, input int rc, input int rd,
                             input int ev, input int es, input int ec, input int est,
                             input int eo);
    vec_t r;
    r.v = 1'(v); r.s = 8'(s); r.rc = 1'(rc); r.rd = 1'(rd);
    r.e_valid = 1'(ev); r.e_seq = 8'(es); r.e_cnt = 3'(ec);
    r.e_stall = 1'(est); r.e_ovf = 1'(eo);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [7:0] s, input logic rc, input logic rd);
    pkt_i = mk(v, s);
    rec   = rc;
    rdy   = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: in-order queue of accepted packets, bounded at DEPTH.
  task automatic model_check();
    chk("rnd_valid", 32'(pkt_o.valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("rnd_seq", 32'(pkt_o.seq_no), 32'(mq[0].seq_no));
      chk("rnd_addr", pkt_o.addr, mq[0].addr);
    end
    chk("rnd_count", 32'(cnt), 32'(mq.size()));
    chk("rnd_stall", 32'(stall), 32'(m_stall));
    chk("rnd_ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic model_update();
    bit popm;
    memPkt dropped;
    popm = (mq.size() != 0) && rdy;
    if (rec) begin
      mq.delete();
      m_stall = 1'b0;
    end else begin
      if (popm) dropped = mq.pop_front();
      if (pkt_i.valid) begin
        if (mq.size() < DEPTH) mq.push_back(pkt_i);
        else m_ovf = 1'b1;
      end
      m_stall = (mq.size() >= DEPTH - MARGIN);
    end
  endtask

  vec_t tbl[10];

  initial begin
    // Back-pressure, full push+pop, overflow, recovery.
    tbl[0] = V(1, 10, 0, 0,  0,  0, 0, 0, 0);
    tbl[1] = V(1, 11, 0, 0,  1, 10, 1, 0, 0);
    tbl[2] = V(1, 12, 0, 0,  1, 10, 2, 1, 0);
    tbl[3] = V(1, 13, 0, 0,  1, 10, 3, 1, 0);
    tbl[4] = V(0,  0, 0, 0,  1, 10, 4, 1, 0);
    tbl[5] = V(1, 20, 0, 1,  1, 10, 4, 1, 0);
    tbl[6] = V(1, 30, 0, 0,  1, 11, 4, 1, 0);
    tbl[7] = V(0,  0, 0, 1,  1, 11, 4, 1, 1);
    tbl[8] = V(1, 50, 1, 0,  1, 12, 3, 1, 1);
    tbl[9] = V(0,  0, 0, 1,  0,  0, 0, 0, 1);

    reset_n = 1'b0;
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    #3;
    chk("rst_valid", 32'(pkt_o.valid), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    #9 reset_n = 1'b1;
    tick();

    // Streaming with LSU always ready: one-cycle latency, occupancy <= 1.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b1);
      @(negedge clk);
      chk("stream_valid", 32'(pkt_o.valid), (i == 1) ? 32'd0 : 32'd1);
      if (i > 1) chk("stream_seq", 32'(pkt_o.seq_no), 32'(i - 1));
      chk("stream_count", 32'(cnt), (i == 1) ? 32'd0 : 32'd1);
      chk("stream_stall", 32'(stall), 32'd0);
      tick();
    end
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("stream_last_seq", 32'(pkt_o.seq_no), 32'd8);
    chk("stream_last_count", 32'(cnt), 32'd1);
    tick();
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("stream_drained", 32'(pkt_o.valid), 32'd0);
    tick();

    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].v, tbl[k].s, tbl[k].rc, tbl[k].rd);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", k), 32'(pkt_o.valid), 32'(tbl[k].e_valid));
      if (tbl[k].e_valid) chk($sformatf("tbl%0d_seq", k), 32'(pkt_o.seq_no), 32'(tbl[k].e_seq));
      chk($sformatf("tbl%0d_count", k), 32'(cnt), 32'(tbl[k].e_cnt));
      chk($sformatf("tbl%0d_stall", k), 32'(stall), 32'(tbl[k].e_stall));
      chk($sformatf("tbl%0d_ovf", k), 32'(ovf), 32'(tbl[k].e_ovf));
      tick();
    end

    // Asynchronous reset with two entries held.
    drive(1'b1, 8'd60, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'd61, 1'b0, 1'b0);
    tick();
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_areset_count", 32'(cnt), 32'd2);
    #1 reset_n = 1'b0;
    #1;
    chk("areset_valid", 32'(pkt_o.valid), 32'd0);
    chk("areset_seq", 32'(pkt_o.seq_no), 32'd0);
    chk("areset_addr", pkt_o.addr, 32'd0);
    chk("areset_count", 32'(cnt), 32'd0);
    chk("areset_ovf", 32'(ovf), 32'd0);
    tick();
    #2 reset_n = 1'b1;
    tick();
    drive(1'b1, 8'd40, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_reset_empty", 32'(pkt_o.valid), 32'd0);
    tick();
    drive(1'b0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_reset_valid", 32'(pkt_o.valid), 32'd1);
    chk("post_reset_seq", 32'(pkt_o.seq_no), 32'd40);
    chk("post_reset_count", 32'(cnt), 32'd1);
    tick();
    drive(1'b0, 8'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("post_reset_pop_seq", 32'(pkt_o.seq_no), 32'd40);
    tick();

    // Randomized traffic against the queue model; starts from empty.
    mq.delete();
    m_stall = 1'b0;
    m_ovf   = 1'b0;
    for (int c = 0; c < 600; c++) begin
      pkt_i        = mk(1'($urandom_range(0, 3) != 0), 8'($urandom));
      pkt_i.addr   = $urandom;
      pkt_i.op     = 4'($urandom);
      rec          = 1'($urandom_range(0, 24) == 0);
      rdy          = 1'($urandom_range(0, 2) != 0);
      @(negedge clk);
      model_check();
      tick();
      model_update();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
